// File: rtl/spi_responder.sv
// SPI mode-0 responder: synchronizes the off-chip SPI pins into clk, shifts
// MSB-first frames in and out, and hands received frames to a valid/ready
// stream. Sticky flags report dropped RX frames and TX frames with no data.
module spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oen,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun,
    output logic                  tx_underrun,
    input  logic                  status_clr,
    output logic                  busy
);

    localparam int            CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // synchronizer chains; fill_q marks when the chains hold real pin values
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, fill_q;
    logic                   sclk_dly_q;
    logic                   sclk_s, cs_s, mosi_s, rise, fall;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-2:0]  rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   ovr_q, ovr_d, und_q, und_d;
    logic                   armed_q, armed_d;

    logic                   load, frame_done, xfer, ovr_set, und_set;
    logic [DATA_WIDTH-1:0]  frame;

    // pin synchronizers and SCLK delay for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            sclk_dly_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sclk_dly_q  <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_dly_q;
    assign fall   = ~sclk_s & sclk_dly_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next-state, shift datapath, RX handshake and sticky flags
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        armed_d    = armed_q;
        load       = 1'b0;
        frame_done = 1'b0;
        ovr_set    = 1'b0;
        und_set    = 1'b0;
        tx_ready   = 1'b0;
        frame      = {rx_sr_q, mosi_s};
        xfer       = rx_valid_q & rx_ready;

        // only a CS seen high after reset may start a transaction, so a
        // reset under a held-low CS waits for a fresh falling edge
        if (fill_q[SYNC_STAGES-1] && cs_s) armed_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (armed_q && !cs_s) begin
                    state_d = ACTIVE;
                    load    = 1'b1;
                    cnt_d   = '0;
                    rx_sr_d = '0;
                end
            end
            ACTIVE: begin
                if (cs_s) begin
                    // partial frame is discarded
                    state_d = IDLE;
                    cnt_d   = '0;
                    rx_sr_d = '0;
                    tx_sr_d = '0;
                end else begin
                    if (rise) begin
                        rx_sr_d = frame[DATA_WIDTH-2:0];
                        if (cnt_q == LAST_BIT) begin
                            cnt_d      = '0;
                            frame_done = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    if (fall) begin
                        if (cnt_q == '0) load = 1'b1;
                        else             tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
        endcase

        if (load) begin
            if (tx_valid) begin
                tx_sr_d  = tx_data;
                tx_ready = 1'b1;
            end else begin
                tx_sr_d = '0;
                und_set = 1'b1;
            end
        end

        // a frame landing in the same cycle as a transfer replaces the old one
        if (frame_done && (!rx_valid_q || xfer)) begin
            rx_data_d  = frame;
            rx_valid_d = 1'b1;
        end else begin
            if (frame_done) ovr_set = 1'b1;
            if (xfer)       rx_valid_d = 1'b0;
        end

        ovr_d = ovr_set ? 1'b1 : (status_clr ? 1'b0 : ovr_q);
        und_d = und_set ? 1'b1 : (status_clr ? 1'b0 : und_q);
    end

    // datapath and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            und_q      <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
            und_q      <= und_d;
            armed_q    <= armed_d;
        end
    end

    assign busy         = (state_q == ACTIVE);
    assign spi_miso     = busy ? tx_sr_q[DATA_WIDTH-1] : 1'b0;
    assign spi_miso_oen = ~busy;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_overrun   = ovr_q;
    assign tx_underrun  = und_q;

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: acts as an SPI mode-0 initiator at clk/8, checks
// directed frame vectors, multi-cycle corner cases and a randomized run
// against a frame-level model of the RX slot and the sticky flags.
module tb_spi_responder;

    localparam int DW = 8;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic          spi_miso, spi_miso_oen;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0, tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid, rx_ready = 1'b0;
    logic          rx_overrun, tx_underrun;
    logic          status_clr = 1'b0;
    logic          busy;

    always #5 clk = ~clk;

    spi_responder #(.SYNC_STAGES(SS), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oen(spi_miso_oen),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
        .status_clr(status_clr), .busy(busy)
    );

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] got_q[$];
    int            rdy_cnt = 0;

    // stream monitor: collects transferred bytes and tx_ready pulses
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (tx_ready) rdy_cnt++;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_clr();
        status_clr = 1'b1;
        wait_clk(1);
        status_clr = 1'b0;
        wait_clk(1);
    endtask

    // n SCLK periods, MSB first; MISO captured at each rising edge.
    // rdy_last raises rx_ready for the one cycle the last rise is registered.
    task automatic sclk_bits(input logic [31:0] bits, input int n, input bit rdy_last,
                             output logic [31:0] miso);
        miso = '0;
        for (int i = 0; i < n; i++) begin
            spi_mosi = bits[n-1-i];
            wait_clk(4);
            spi_sclk = 1'b1;
            miso[n-1-i] = spi_miso;
            if (rdy_last && i == n-1) begin
                wait_clk(SS);
                rx_ready = 1'b1;
                wait_clk(1);
                rx_ready = 1'b0;
                wait_clk(3 - SS);
            end else begin
                wait_clk(4);
            end
            spi_sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] bits, input int n, input bit rdy_last,
                         output logic [31:0] miso, output int early);
        spi_cs_n = 1'b0;
        wait_clk(6);
        early = rdy_cnt;
        sclk_bits(bits, n, rdy_last, miso);
        wait_clk(6);
        spi_cs_n = 1'b1;
        wait_clk(8);
    endtask

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] tx;
        logic       txv;
        logic [7:0] exp_miso;
        logic       exp_under;
        int         exp_early;
        int         exp_total;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] miso;
    int          early;
    logic [7:0]  exp_stream[$];
    logic        slot_full, exp_ovr, exp_und;
    logic [7:0]  slot;

    initial begin
        // load at CS assertion plus the frame-boundary preload give two pulses
        vecs[0] = '{8'h3C, 8'hA5, 1'b1, 8'hA5, 1'b0, 1, 2};
        vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, 1, 2};
        vecs[2] = '{8'h00, 8'hFF, 1'b1, 8'hFF, 1'b0, 1, 2};
        vecs[3] = '{8'h5A, 8'h81, 1'b0, 8'h00, 1'b1, 0, 0};
        vecs[4] = '{8'hC7, 8'h6E, 1'b1, 8'h6E, 1'b0, 1, 2};

        // reset state
        wait_clk(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_oen", 32'(spi_miso_oen), 1);
        chk("rst_miso", 32'(spi_miso), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_tx_ready", 32'(tx_ready), 0);
        chk("rst_ovr", 32'(rx_overrun), 0);
        chk("rst_und", 32'(tx_underrun), 0);
        rst_n = 1'b1;
        wait_clk(6);

        // directed frame vectors
        for (int v = 0; v < 5; v++) begin
            tx_data = vecs[v].tx; tx_valid = vecs[v].txv; rx_ready = 1'b1;
            got_q.delete(); rdy_cnt = 0;
            frame(32'(vecs[v].mosi), 8, 1'b0, miso, early);
            chk($sformatf("vec%0d_miso", v), miso, 32'(vecs[v].exp_miso));
            chk($sformatf("vec%0d_rxcnt", v), got_q.size(), 1);
            if (got_q.size() > 0) chk($sformatf("vec%0d_rxdata", v), 32'(got_q[0]), 32'(vecs[v].mosi));
            chk($sformatf("vec%0d_rdy_early", v), early, vecs[v].exp_early);
            chk($sformatf("vec%0d_rdy_total", v), rdy_cnt, vecs[v].exp_total);
            chk($sformatf("vec%0d_und", v), 32'(tx_underrun), 32'(vecs[v].exp_under));
            chk($sformatf("vec%0d_oen_idle", v), 32'(spi_miso_oen), 1);
            pulse_clr();
            chk($sformatf("vec%0d_und_clr", v), 32'(tx_underrun), 0);
        end

        // back-to-back frames with no consumer: second frame dropped
        tx_data = 8'h5A; tx_valid = 1'b1; rx_ready = 1'b0;
        got_q.delete();
        frame({16'h0, 8'h11, 8'h22}, 16, 1'b0, miso, early);
        chk("b2b_rx_valid", 32'(rx_valid), 1);
        chk("b2b_rx_data", 32'(rx_data), 32'h11);
        chk("b2b_ovr", 32'(rx_overrun), 1);
        pulse_clr();
        chk("b2b_ovr_clr", 32'(rx_overrun), 0);
        chk("b2b_rx_data_kept", 32'(rx_data), 32'h11);
        chk("b2b_rx_valid_kept", 32'(rx_valid), 1);
        rx_ready = 1'b1;
        wait_clk(2);
        chk("b2b_drain_cnt", got_q.size(), 1);
        chk("b2b_rx_valid_drained", 32'(rx_valid), 0);

        // CS dropped after 5 bits, then a full frame
        got_q.delete();
        frame(32'h15, 5, 1'b0, miso, early);
        chk("part_oen_between", 32'(spi_miso_oen), 1);
        chk("part_busy_between", 32'(busy), 0);
        chk("part_no_rx", got_q.size(), 0);
        frame(32'h81, 8, 1'b0, miso, early);
        chk("part_rxcnt", got_q.size(), 1);
        if (got_q.size() > 0) chk("part_rxdata", 32'(got_q[0]), 32'h81);

        // transfer coincides with completion of the next frame
        rx_ready = 1'b0;
        got_q.delete();
        frame(32'h44, 8, 1'b0, miso, early);
        chk("coin_first_valid", 32'(rx_valid), 1);
        frame(32'h99, 8, 1'b1, miso, early);
        chk("coin_rx_valid", 32'(rx_valid), 1);
        chk("coin_rx_data", 32'(rx_data), 32'h99);
        chk("coin_ovr", 32'(rx_overrun), 0);
        chk("coin_drained_cnt", got_q.size(), 1);
        if (got_q.size() > 0) chk("coin_drained_data", 32'(got_q[0]), 32'h44);
        rx_ready = 1'b1;
        wait_clk(2);

        // randomized frames against a frame-level slot model
        got_q.delete(); exp_stream.delete();
        slot_full = 1'b0; slot = '0; exp_ovr = 1'b0; exp_und = 1'b0;
        pulse_clr();
        for (int k = 0; k < 14; k++) begin
            logic [7:0] mb, tb;
            logic       tv, rr;
            mb = 8'($urandom); tb = 8'($urandom);
            tv = 1'($urandom_range(0, 1)); rr = 1'($urandom_range(0, 1));
            tx_data = tb; tx_valid = tv; rx_ready = rr;
            if (rr && slot_full) begin exp_stream.push_back(slot); slot_full = 1'b0; end
            frame(32'(mb), 8, 1'b0, miso, early);
            if (rr)              exp_stream.push_back(mb);
            else if (!slot_full) begin slot = mb; slot_full = 1'b1; end
            else                 exp_ovr = 1'b1;
            if (!tv) exp_und = 1'b1;
            chk($sformatf("rnd%0d_miso", k), miso, tv ? 32'(tb) : 32'h0);
            chk($sformatf("rnd%0d_rx_valid", k), 32'(rx_valid), 32'(slot_full));
            if (slot_full) chk($sformatf("rnd%0d_rx_data", k), 32'(rx_data), 32'(slot));
            chk($sformatf("rnd%0d_ovr", k), 32'(rx_overrun), 32'(exp_ovr));
            chk($sformatf("rnd%0d_und", k), 32'(tx_underrun), 32'(exp_und));
            if ($urandom_range(0, 3) == 0) begin
                pulse_clr();
                exp_ovr = 1'b0; exp_und = 1'b0;
            end
        end
        rx_ready = 1'b1;
        wait_clk(2);
        if (slot_full) exp_stream.push_back(slot);
        chk("rnd_stream_len", got_q.size(), exp_stream.size());
        for (int i = 0; i < exp_stream.size() && i < got_q.size(); i++)
            chk($sformatf("rnd_stream%0d", i), 32'(got_q[i]), 32'(exp_stream[i]));

        // reset mid-frame with CS held low
        tx_valid = 1'b0; rx_ready = 1'b1;
        got_q.delete(); rdy_cnt = 0;
        spi_cs_n = 1'b0;
        wait_clk(6);
        sclk_bits(32'h5, 3, 1'b0, miso);
        chk("mrst_pre_busy", 32'(busy), 1);
        chk("mrst_pre_und", 32'(tx_underrun), 1);
        rst_n = 1'b0;
        wait_clk(1);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_oen", 32'(spi_miso_oen), 1);
        chk("mrst_miso", 32'(spi_miso), 0);
        chk("mrst_und", 32'(tx_underrun), 0);
        chk("mrst_ovr", 32'(rx_overrun), 0);
        chk("mrst_rx_valid", 32'(rx_valid), 0);
        chk("mrst_rx_data", 32'(rx_data), 0);
        chk("mrst_tx_ready", 32'(tx_ready), 0);
        rst_n = 1'b1;
        tx_data = 8'hC3; tx_valid = 1'b1;
        sclk_bits(32'h1D, 5, 1'b0, miso);
        wait_clk(6);
        chk("mrst_hold_busy", 32'(busy), 0);
        chk("mrst_hold_rx", got_q.size(), 0);
        chk("mrst_hold_rdy", rdy_cnt, 0);
        spi_cs_n = 1'b1;
        wait_clk(8);
        frame(32'h6E, 8, 1'b0, miso, early);
        chk("mrst_after_miso", miso, 32'hC3);
        chk("mrst_after_rxcnt", got_q.size(), 1);
        if (got_q.size() > 0) chk("mrst_after_rxdata", 32'(got_q[0]), 32'h6E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_responder.md
SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on spi_sclk/spi_cs_n/spi_mosi (minimum 2).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bits per SPI frame.
REQ-003 SHALL have port clk, input, 1, system clock; the single clock of the block.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port spi_sclk, input, 1, SPI clock from the off-chip initiator; asynchronous to clk.
REQ-006 SHALL have port spi_cs_n, input, 1, chip select from the initiator, active low, asynchronous.
REQ-007 SHALL have port spi_mosi, input, 1, initiator-to-responder serial data, asynchronous.
REQ-008 SHALL have port spi_miso, output, 1, responder-to-initiator serial data.
REQ-009 SHALL have port spi_miso_oen, output, 1, pad output enable, active low (0 = drive).
REQ-010 SHALL have ports tx_data, input, DATA_WIDTH, and tx_valid, input, 1: the next byte to shift out.
REQ-011 SHALL have port tx_ready, output, 1, asserted in the cycle tx_data is loaded.
REQ-012 SHALL have ports rx_data, output, DATA_WIDTH; rx_valid, output, 1; and rx_ready, input, 1: the received-byte stream.
REQ-013 SHALL have ports rx_overrun and tx_underrun, outputs, 1 each, sticky status flags.
REQ-014 SHALL have port status_clr, input, 1, single-cycle clear of both sticky flags.
REQ-015 SHALL have port busy, output, 1, high while state is ACTIVE.

Function
REQ-016 SHALL use SPI mode 0 (CPOL=0, CPHA=0), MSB first: sample MOSI on SCLK rise, update MISO on SCLK fall.
REQ-017 SHALL pass each SPI input through SYNC_STAGES flops (reset values: sclk 0, cs_n 1, mosi 0), then detect SCLK edges by comparing the synced value with a one-cycle-delayed copy.
REQ-018 SHALL support SCLK frequencies up to clk/8; faster SCLK is unsupported and its behaviour is undefined.
REQ-019 SHALL implement FSM states IDLE and ACTIVE; IDLE->ACTIVE when synced cs_n is 0; ACTIVE->IDLE when synced cs_n is 1.
REQ-020 On IDLE->ACTIVE, SHALL load the TX shift register from tx_data and pulse tx_ready for 1 cycle if tx_valid=1; otherwise SHALL load all zeros and set tx_underrun.
REQ-021 spi_miso SHALL equal the TX shift-register MSB while ACTIVE and 0 while IDLE; spi_miso_oen SHALL be 0 while ACTIVE and 1 while IDLE.
REQ-022 On each synced SCLK rise in ACTIVE, SHALL shift synced mosi into the RX shift-register LSB and increment the bit counter (modulo DATA_WIDTH).
REQ-023 On each synced SCLK fall in ACTIVE, SHALL shift the TX register left by one; if the counter is 0 (frame boundary) it SHALL instead reload per REQ-020 rules (tx_ready pulse or tx_underrun).
REQ-024 On the DATA_WIDTH-th rise, SHALL transfer the completed frame to rx_data and set rx_valid; rx_data SHALL be stable while rx_valid=1.
REQ-025 A transfer SHALL occur when rx_valid and rx_ready are both 1; rx_valid SHALL clear on the next cycle unless a new frame completes in that same cycle, in which case rx_valid stays 1 with the new data and no overrun occurs.
REQ-026 If a frame completes while rx_valid=1 and no transfer occurs that cycle, SHALL drop the new frame, keep the old rx_data, and set rx_overrun.
REQ-027 CS deassertion mid-frame SHALL discard the partial frame, reset the bit counter to 0, and SHALL NOT assert rx_valid or tx_ready.
REQ-028 status_clr SHALL clear rx_overrun and tx_underrun; if a set event occurs in the same cycle, set SHALL win.
REQ-029 SCLK edges SHALL be ignored while IDLE.

Reset
REQ-030 When rst_n=0 at a clk rise: state IDLE; bit counter 0; shift registers 0; rx_data 0; rx_valid, tx_ready, rx_overrun, tx_underrun, busy, spi_miso all 0; spi_miso_oen 1; synchronizers at REQ-017 values.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no rx_valid, and the block SHALL wait for a fresh cs_n high->low before responding.

Verification
REQ-032 tx_data=0xA5, tx_valid=1, rx_ready=1; initiator sends 0x3C over 8 SCLKs at clk/8 -> initiator receives 0xA5; rx_data=0x3C, rx_valid pulses once; tx_ready pulses once at CS assertion.
REQ-033 Two back-to-back frames 0x11, 0x22 with rx_ready=0 -> rx_data=0x11, rx_valid=1, rx_overrun=1; status_clr -> rx_overrun=0, rx_data still 0x11.
REQ-034 tx_valid=0 at CS assertion -> MISO shifts 0x00, tx_underrun=1, tx_ready never pulses.
REQ-035 CS deasserted after 5 SCLKs, then a full frame 0x81 -> only one rx_valid, with rx_data=0x81; spi_miso_oen=1 between frames.
REQ-036 rst_n=0 for 1 cycle after bit 3 of a frame, CS held low -> all outputs at reset values; no rx_valid until CS toggles high then low and a full frame completes.
REQ-037 rx_ready asserted in the exact cycle the next frame completes -> no overrun; rx_valid stays 1 and rx_data updates to the new byte.
